// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types, stage/source indices and sizing helper for pipe_ctrl
package pipe_ctrl_pkg;

    // Controller state: idle, or inside the post-redirect bubble window.
    typedef enum logic {
        PC_IDLE  = 1'b0,
        PC_FLUSH = 1'b1
    } pc_state_e;

    // Pipeline register indices, youngest first.
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;

    // Redirect source indices; lower index wins.
    localparam int JSRC_TRAP = 0;
    localparam int JSRC_BR   = 1;

    // Bits needed to represent any value in 0..max_val (never less than one).
    function automatic int cnt_bits(input int max_val);
        int b;
        b = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) <= max_val) begin
                b = i + 1;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/pipe_ctrl_jmp_arb.sv
// rtl/pipe_ctrl_jmp_arb.sv - fixed-priority redirect source picker (lowest index wins)
module jmp_arb #(
    parameter int NJSRC  = 2,
    parameter int ADDR_W = 32,
    parameter int SRC_W  = 1
) (
    input  logic [NJSRC-1:0]        req_i,
    input  logic [NJSRC*ADDR_W-1:0] addr_i,
    output logic                    valid_o,
    output logic [SRC_W-1:0]        idx_o,
    output logic [NJSRC-1:0]        gnt_o,
    output logic [ADDR_W-1:0]       addr_o
);

    // Scan from the lowest-priority source down so the lowest set index is the final write.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        gnt_o   = '0;
        addr_o  = '0;
        for (int s = NJSRC - 1; s >= 0; s--) begin
            if (req_i[s]) begin
                valid_o  = 1'b1;
                idx_o    = SRC_W'(s);
                gnt_o    = '0;
                gnt_o[s] = 1'b1;
                addr_o   = addr_i[s*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard controller: redirect arbitration, hold decode, flush window (option: PIPE_CTRL_PERF_EN)
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int NSTAGE    = 4,
    parameter int NJSRC     = 2,
    parameter int JMP_STG   = STG_EX,
    parameter int FLUSH_CYC = 2,
    localparam int SRC_W    = (NJSRC > 1) ? $clog2(NJSRC) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NJSRC-1:0]        jump_en_i,
    input  logic [NJSRC*ADDR_W-1:0] jump_addr_i,
    input  logic [NSTAGE-1:0]       hold_req_i,
    output logic                    jump_en_o,
    output logic [ADDR_W-1:0]       jump_addr_o,
    output logic [SRC_W-1:0]        jump_src_o,
    output logic [NJSRC-1:0]        jump_ack_o,
    output logic [NSTAGE-1:0]       stall_o,
    output logic [NSTAGE-1:0]       flush_o,
    output logic                    busy_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]             perf_stall_cnt_o,
    output logic [31:0]             perf_flush_cnt_o
`endif
);

    // Counter holds the number of extra flush cycles still owed after the current one.
    localparam int CNT_MAX = (FLUSH_CYC > 2) ? (FLUSH_CYC - 2) : 0;
    localparam int CNT_W   = cnt_bits(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CNT_MAX);

    // Stages younger than the resolve stage hold wrong-path instructions after a redirect.
    localparam logic [NSTAGE-1:0] FRONT_MASK = NSTAGE'((1 << JMP_STG) - 1);

    pc_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              arb_valid;
    logic [SRC_W-1:0]  arb_idx;
    logic [NJSRC-1:0]  arb_gnt;
    logic [ADDR_W-1:0] arb_addr;

    logic [NSTAGE-1:0] hold_stall;
    logic [NSTAGE-1:0] hold_flush;
    logic              hold_blk;
    logic              accept;

    jmp_arb #(
        .NJSRC  (NJSRC),
        .ADDR_W (ADDR_W),
        .SRC_W  (SRC_W)
    ) u_jmp_arb (
        .req_i   (jump_en_i),
        .addr_i  (jump_addr_i),
        .valid_o (arb_valid),
        .idx_o   (arb_idx),
        .gnt_o   (arb_gnt),
        .addr_o  (arb_addr)
    );

    // Hold decode: every stage at or below the oldest holding stage stalls, the next older one gets a bubble.
    always_comb begin
        hold_stall = '0;
        hold_flush = '0;
        hold_blk   = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            for (int j = i; j < NSTAGE; j++) begin
                if (hold_req_i[j]) begin
                    hold_stall[i] = 1'b1;
                end
            end
            if (i >= JMP_STG && hold_req_i[i]) begin
                hold_blk = 1'b1;
            end
        end
        for (int i = 1; i < NSTAGE; i++) begin
            hold_flush[i] = hold_req_i[i-1] & ~hold_stall[i];
        end
    end

    // Next state and all control outputs; a hold at or past the resolve stage pre-empts any redirect.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        jump_en_o   = 1'b0;
        jump_addr_o = '0;
        jump_src_o  = '0;
        jump_ack_o  = '0;
        stall_o     = '0;
        flush_o     = '0;
        accept      = arb_valid & ~hold_blk;

        if (accept) begin
            // Younger holds are moot: their instructions are being squashed.
            jump_en_o   = 1'b1;
            jump_addr_o = arb_addr;
            jump_src_o  = arb_idx;
            jump_ack_o  = arb_gnt;
            flush_o     = FRONT_MASK;
            if (FLUSH_CYC > 1) begin
                state_d = PC_FLUSH;
                cnt_d   = CNT_INIT;
            end
        end else if (state_q == PC_FLUSH) begin
            // Keep bubbling the front end while fetch catches up; older holds still act on older stages.
            flush_o = FRONT_MASK | (hold_blk ? hold_flush : '0);
            stall_o = hold_blk ? (hold_stall & ~FRONT_MASK) : '0;
            if (!stall_o[JMP_STG]) begin
                if (cnt_q == '0) begin
                    state_d = PC_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end else begin
            stall_o = hold_stall;
            flush_o = hold_flush;
        end

        if (!rst) begin
            jump_en_o   = 1'b0;
            jump_addr_o = '0;
            jump_src_o  = '0;
            jump_ack_o  = '0;
            stall_o     = '0;
            flush_o     = '0;
        end
    end

    assign busy_o = (|stall_o) | (|flush_o);

    // State and flush-window counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= PC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    // Saturating event counters for stall cycles and taken redirects.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if ((|stall_o) && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (jump_en_o && (perf_flush_q != 32'hFFFF_FFFF)) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o = rst ? perf_stall_q : 32'd0;
    assign perf_flush_cnt_o = rst ? perf_flush_q : 32'd0;
`endif

endmodule
